// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath.
//   FFT_POINTS / FFT_LOG2 : frame size and index width
//   FFT_N / FFT_W         : component width exponent and derived width (W = 2**N)
//   bitrev3               : 3-bit index bit reversal (1->4, 3->6, ...)
package fft_pkg;

    localparam int FFT_POINTS = 8;
    localparam int FFT_LOG2   = 3;
    localparam int FFT_N      = 3;
    localparam int FFT_W      = 2 ** FFT_N;

    function automatic logic [FFT_LOG2-1:0] bitrev3(input logic [FFT_LOG2-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer of 8 complex registers, stored in bit-reversed slot order.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr_en/wr_slot       write enable and destination slot
//   wr_r/wr_i           sample components to store
//   zero_en/zero_from   clear every slot whose sample index (bitrev of slot)
//                       is >= zero_from; used to pad a short frame
//   data_r/data_i       flattened contents, slot j at bits [j*W +: W]
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int W = FFT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [FFT_LOG2-1:0]     wr_slot,
    input  logic [W-1:0]            wr_r,
    input  logic [W-1:0]            wr_i,
    input  logic                    zero_en,
    input  logic [FFT_LOG2-1:0]     zero_from,
    output logic [FFT_POINTS*W-1:0] data_r,
    output logic [FFT_POINTS*W-1:0] data_i
);

    logic [W-1:0] re [FFT_POINTS];
    logic [W-1:0] im [FFT_POINTS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < FFT_POINTS; s++) begin
                re[s] <= '0;
                im[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < FFT_POINTS; s++) begin
                // The written slot always belongs to an index below zero_from,
                // so the write and the zero fill never target the same slot.
                if (wr_en && (wr_slot == FFT_LOG2'(s))) begin
                    re[s] <= wr_r;
                    im[s] <= wr_i;
                end else if (zero_en && (bitrev3(FFT_LOG2'(s)) >= zero_from)) begin
                    re[s] <= '0;
                    im[s] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < FFT_POINTS; g++) begin : g_flat
        assign data_r[g*W +: W] = re[g];
        assign data_i[g*W +: W] = im[g];
    end

endmodule

// File: rtl/fft_input_loader.sv
// Serial-to-parallel input stage of the 8-point FFT. Packs 8 complex samples
// per frame into a ping-pong pair of banks, already in bit-reversed order.
// Optional feature: define FFT_IN_PRESCALE_EN to arithmetically shift each
// accepted component right by one before storage.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid/in_ready              sample handshake
//   in_r/in_i/in_last              sample components, end-of-frame marker
//   out_valid/out_ready            frame handshake
//   out_r/out_i                    frame, slot j at bits [j*W +: W]
//   frame_err                      one-cycle pulse on a frame-length error
module fft_input_loader
    import fft_pkg::*;
#(
    parameter  int N = FFT_N,
    localparam int W = 2 ** N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_r,
    input  logic [W-1:0]            in_i,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FFT_POINTS*W-1:0] out_r,
    output logic [FFT_POINTS*W-1:0] out_i,
    output logic                    frame_err
);

    logic                    wr_sel;
    logic                    rd_sel;
    logic [1:0]              full;
    logic [FFT_LOG2-1:0]     widx;
    logic                    run;
    logic                    accept;
    logic                    close;
    logic                    early;
    logic                    consume;
    logic [W-1:0]            st_r;
    logic [W-1:0]            st_i;
    logic [FFT_POINTS*W-1:0] bank_r [2];
    logic [FFT_POINTS*W-1:0] bank_i [2];

    // run holds in_ready low until the first edge after reset release.
    assign in_ready  = run && !full[wr_sel];
    assign out_valid = full[rd_sel];
    assign accept    = in_valid && in_ready;
    assign close     = accept && (in_last || (widx == '1));
    assign early     = accept && in_last && (widx != '1);
    assign consume   = out_valid && out_ready;

`ifdef FFT_IN_PRESCALE_EN
    assign st_r = $signed(in_r) >>> 1;
    assign st_i = $signed(in_i) >>> 1;
`else
    assign st_r = in_r;
    assign st_i = in_i;
`endif

    // Close and consume always address different banks: close needs
    // full[wr_sel]==0 while consume needs full[rd_sel]==1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            full      <= '0;
            widx      <= '0;
            frame_err <= 1'b0;
        end else begin
            run       <= 1'b1;
            frame_err <= accept && (in_last != (widx == '1));
            if (close) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
                widx         <= '0;
            end else if (accept) begin
                widx <= widx + 1'b1;
            end
            if (consume) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(.W(W)) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (accept && (wr_sel == 1'(b))),
            .wr_slot   (bitrev3(widx)),
            .wr_r      (st_r),
            .wr_i      (st_i),
            .zero_en   (early && (wr_sel == 1'(b))),
            .zero_from (widx + 1'b1),
            .data_r    (bank_r[b]),
            .data_i    (bank_i[b])
        );
    end

    assign out_r = rd_sel ? bank_r[1] : bank_r[0];
    assign out_i = rd_sel ? bank_i[1] : bank_i[0];

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

    localparam int W  = 8;
    localparam int FW = 8 * W;

    typedef struct {
        logic [FW-1:0] r;
        logic [FW-1:0] i;
    } frame_t;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic [W-1:0] er;
        logic [W-1:0] ei;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_r = '0;
    logic [W-1:0]  in_i = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_r;
    logic [FW-1:0] out_i;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    int           brev_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int           t2_slots[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [W-1:0] mr[8];
    logic [W-1:0] mi[8];
    int           widx = 0;
    logic         exp_err = 1'b0;
    frame_t       sb[$];
    vec_t         tbl[8];

    always #5 clk = ~clk;

    fft_input_loader #(.N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .frame_err (frame_err)
    );

    function automatic logic [W-1:0] pre(input logic [W-1:0] x);
`ifdef FFT_IN_PRESCALE_EN
        return {x[W-1], x[W-1:1]};
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the reference model from the handshakes seen before
    // the edge, then compare every observable output after it.
    task automatic cycle(output bit acc);
        bit     con;
        frame_t f;
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        if (con && sb.size() != 0) void'(sb.pop_front());
        exp_err = 1'b0;
        if (acc) begin
            mr[widx] = pre(in_r);
            mi[widx] = pre(in_i);
            if (widx == 7 || in_last) begin
                exp_err = (widx == 7) != in_last;
                for (int j = 0; j < 8; j++) begin
                    f.r[j*W +: W] = (brev_tab[j] <= widx) ? mr[brev_tab[j]] : '0;
                    f.i[j*W +: W] = (brev_tab[j] <= widx) ? mi[brev_tab[j]] : '0;
                end
                sb.push_back(f);
                widx = 0;
            end else begin
                widx++;
            end
        end
        @(posedge clk);
        #1;
        chk("frame_err", frame_err, exp_err);
        chk("out_valid", out_valid, sb.size() != 0);
        chk("in_ready", in_ready, sb.size() < 2);
        if (sb.size() != 0) begin
            chk("out_r", out_r, sb[0].r);
            chk("out_i", out_i, sb[0].i);
        end
    endtask

    task automatic send(input logic [W-1:0] r, input logic [W-1:0] i, input logic last);
        bit acc;
        int n = 0;
        in_valid = 1'b1;
        in_r     = r;
        in_i     = i;
        in_last  = last;
        do begin
            cycle(acc);
            n++;
        end while (!acc && n < 40);
        chk("send_accept", acc, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            cycle(acc);
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;

`ifdef FFT_IN_PRESCALE_EN
        tbl[0] = '{8'h81, 8'h7F, 8'hC0, 8'h3F};
        tbl[1] = '{8'h7F, 8'h81, 8'h3F, 8'hC0};
        tbl[2] = '{8'h00, 8'h40, 8'h00, 8'h20};
        tbl[3] = '{8'hFF, 8'h01, 8'hFF, 8'h00};
        tbl[4] = '{8'h01, 8'hFF, 8'h00, 8'hFF};
        tbl[5] = '{8'h80, 8'h7E, 8'hC0, 8'h3F};
        tbl[6] = '{8'h7E, 8'h80, 8'h3F, 8'hC0};
        tbl[7] = '{8'h40, 8'h00, 8'h20, 8'h00};
`else
        tbl[0] = '{8'h81, 8'h7F, 8'h81, 8'h7F};
        tbl[1] = '{8'h7F, 8'h81, 8'h7F, 8'h81};
        tbl[2] = '{8'h00, 8'h40, 8'h00, 8'h40};
        tbl[3] = '{8'hFF, 8'h01, 8'hFF, 8'h01};
        tbl[4] = '{8'h01, 8'hFF, 8'h01, 8'hFF};
        tbl[5] = '{8'h80, 8'h7E, 8'h80, 8'h7E};
        tbl[6] = '{8'h7E, 8'h80, 8'h7E, 8'h80};
        tbl[7] = '{8'h40, 8'h00, 8'h40, 8'h00};
`endif

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_i", out_i, 0);
        rst = 1'b1;
        chk("rel_in_ready_pre", in_ready, 0);
        cycle(acc);
        chk("rel_in_ready_post", in_ready, 1);

        // Natural-order frame 0..7 comes out bit-reversed
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) send(8'(s), 8'(0 - s), s == 7);
        chk("t2_valid", out_valid, 1);
        for (int j = 0; j < 8; j++) chk("t2_slot", out_r[j*W +: W], pre(8'(t2_slots[j])));
        drain();

        // Back-pressure: 24 offers, only 16 fit in the two banks
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (k < 24);
            in_r     = 8'(k + 32);
            in_i     = 8'(255 - k);
            in_last  = (k % 8) == 7;
            cycle(acc);
            if (acc) k++;
        end
        chk("t3_accepted", k, 16);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cycle(acc);
        out_ready = 1'b0;
        chk("t3_ready_after_pulse", in_ready, 1);
        out_ready = 1'b1;
        for (; k < 24; k++) send(8'(k + 32), 8'(255 - k), (k % 8) == 7);
        drain();

        // Early in_last at index 4 pads with zeros; next frame starts at index 0
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) send(8'(10 + s), 8'(100 + s), s == 4);
        chk("t4_err", frame_err, 1);
        chk("t4_zero_r5", out_r[5*W +: W], 0);
        chk("t4_zero_r3", out_r[3*W +: W], 0);
        chk("t4_zero_r7", out_r[7*W +: W], 0);
        chk("t4_zero_i7", out_i[7*W +: W], 0);
        for (int s = 0; s < 8; s++) send(8'(200 + s), 8'(150 + s), s == 7);
        chk("t4_next_err", frame_err, 0);
        drain();

        // Eight samples without in_last: closes with an error pulse
        for (int s = 0; s < 8; s++) send(8'(50 + s), 8'(60 + s), 1'b0);
        chk("t5_err", frame_err, 1);
        for (int s = 0; s < 8; s++) send(8'(70 + s), 8'(80 + s), s == 7);
        drain();

        // Reset mid-frame with one bank full discards everything
        out_ready = 1'b0;
        for (int s = 0; s < 8; s++) send(8'(90 + s), 8'(91 + s), s == 7);
        for (int s = 0; s < 3; s++) send(8'(110 + s), 8'(111 + s), 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_frame_err", frame_err, 0);
        chk("t6_out_r", out_r, 0);
        sb.delete();
        widx = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t6_ready_pre", in_ready, 0);
        cycle(acc);
        chk("t6_ready_post", in_ready, 1);
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) send(8'(120 + s), 8'(130 + s), s == 7);
        drain();

        // Table-driven component storage (prescale or pass-through)
        out_ready = 1'b0;
        for (int s = 0; s < 8; s++) send(tbl[s].r, tbl[s].i, s == 7);
        for (int j = 0; j < 8; j++) begin
            chk("tbl_r", out_r[j*W +: W], tbl[brev_tab[j]].er);
            chk("tbl_i", out_i[j*W +: W], tbl[brev_tab[j]].ei);
        end
        drain();
        cycle(acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream stage of the 8-point FFT core; feeds the first butterfly stage.
- Accepts complex samples serially, one per handshake, and packs each group of 8 into a frame.
- Presents the frame in parallel, already in bit-reversed order, so the butterfly stages take natural wiring.
- Ping-pong double buffering: one bank fills while the other is held for the core, allowing full-rate streaming.

Parameters:
- N, 3, component width exponent; each real/imag component is W = 2**N bits, two's complement. Matches the butterfly stages.

Ports:
- clk        in   1     clock; all state updates on the rising edge
- rst        in   1     asynchronous, active-low reset
- in_valid   in   1     input sample valid
- in_ready   out  1     loader can accept a sample
- in_r       in   W     input sample, real part
- in_i       in   W     input sample, imaginary part
- in_last    in   1     marks the final sample of a frame
- out_valid  out  1     a full frame is presented
- out_ready  in   1     FFT core consumes the frame
- out_r      out  8*W   frame real parts; slot j = bits [j*W +: W]
- out_i      out  8*W   frame imaginary parts; same slot layout
- frame_err  out  1     one-cycle pulse on a frame-length error

Behaviour:
- Reset (rst low, asynchronous):
  - wr_sel=0, rd_sel=0, full[1:0]=0, write index=0, all bank registers=0.
  - out_valid=0, frame_err=0, in_ready=0.
  - in_ready becomes 1 in the first cycle after rst deasserts.
- Reset mid-operation discards any partial and full frames; there is no recovery of in-flight data.
- Input handshake:
  - A sample is accepted on an edge where in_valid && in_ready.
  - in_ready = !full[wr_sel] (registered flags; no combinational path from out_ready).
- Write storage:
  - Accepted sample k (k = 3-bit write index, 0..7) is stored in slot bitrev(k) of bank wr_sel. bitrev maps 1->4, 3->6, etc.
  - The index increments and wraps 7->0.
- Frame close:
  - On accepting index 7, or on any accepted sample with in_last=1: full[wr_sel] is set, wr_sel toggles, and the index resets to 0.
- Early in_last (at index k<7):
  - Slots for indices k+1..7 of that bank are written to zero on the same edge.
  - frame_err pulses high for one cycle.
- Index 7 accepted with in_last=0: the frame still closes and frame_err pulses. The next sample starts a new frame.
- Output side:
  - out_valid = full[rd_sel].
  - out_r/out_i are driven from bank rd_sel.
  - Latency: out_valid is high in the cycle right after the edge that closed the frame, provided rd_sel points at that bank.
- Output handshake:
  - On out_valid && out_ready: full[rd_sel] clears and rd_sel toggles.
  - out_r/out_i stay stable while out_valid && !out_ready.
- Both banks full: in_ready=0. After a consume edge, in_ready=1 in the following cycle.
- Simultaneous close of bank A and consume of bank B on the same edge: both take effect; there is no conflict.
- No arithmetic is performed except under the optional feature.

Optional Feature:
- FFT_IN_PRESCALE_EN defined:
  - Each accepted component is arithmetically right-shifted by 1 (sign-preserving, truncating toward minus infinity) before storage.
  - This gives headroom against growth through the butterfly stages.
  - Example: 8'h81 -> 8'hC0; 8'h7F -> 8'h3F.
- Undefined: samples are stored unmodified.

Decomposition:
- Shared package fft_pkg:
  - FFT_POINTS=8, FFT_LOG2=3.
  - bitrev3 function.
  - Constant for W derived from N.
- Sub-module fft_frame_bank, one instance per bank:
  - Holds 8 complex registers.
  - Has a write port (slot, data, enable) and a zero-fill-from-slot control.
  - Exposes the flattened contents.
- Full flags, wr_sel/rd_sel and the write index live in fft_input_loader.

Test Plan:
- Stream samples 0..7 (in_r=k, in_i=-k), in_last on k=7, out_ready=1 -> out_valid the cycle after the 8th accept; out_r slots 0..7 = 0,4,2,6,1,5,3,7; frame_err stays 0.
- out_ready=0, 24 samples offered back-to-back -> 16 accepted, then in_ready=0; out data held stable. Pulse out_ready for one cycle -> in_ready=1 on the next cycle; frames appear in arrival order.
- in_last on index 4 (values 10..14) -> frame_err one-cycle pulse; slots bitrev(5..7) = 0; the next sample lands in the other bank at index 0.
- 8 samples without in_last -> frame closes with a frame_err pulse; the 9th sample starts a new frame.
- Assert rst low mid-frame, with one bank full -> out_valid=0 immediately (async); in_ready=1 one cycle after release; the old frame never emerges.
- With FFT_IN_PRESCALE_EN: inputs 8'h81 and 8'h7F -> stored as 8'hC0 and 8'h3F. Without it -> unchanged.
